// File: rtl/jpeg_bit_packer.sv
// Purpose: packs right-aligned variable-length codes MSB-first into a byte stream, with 0xFF->0xFF00 stuffing and a 1s-padded flush.
// Latency: a byte is valid two cycles after the cycle in which its completing code is presented, when the output register is free.
// Backpressure: byte_o/byte_valid_o hold while byte_ready_i is low; in_ready_o drops when the accumulator cannot take a maximum-length code.
//
// Ports:
//   clk_x8_i, rst_n_i                   clock, asynchronous active-low reset
//   in_valid_i/in_ready_o, code_i,
//   code_len_i                          code input handshake; code_i is right-aligned, code_len_i bits valid
//   flush_i                             end-of-scan pulse: pad, drain, then pulse done_o
//   byte_o/byte_valid_o/byte_ready_i    byte output handshake
//   done_o, busy_o, err_o               flush complete pulse, activity flag, sticky over-length error
module jpeg_bit_packer #(
    parameter int IN_WIDTH  = 32,
    parameter int LEN_WIDTH = 6,
    parameter int ACC_WIDTH = 64,
    parameter bit STUFF_EN  = 1'b1
) (
    input  logic                 clk_x8_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_WIDTH-1:0]  code_i,
    input  logic [LEN_WIDTH-1:0] code_len_i,
    input  logic                 flush_i,
    output logic [7:0]           byte_o,
    output logic                 byte_valid_o,
    input  logic                 byte_ready_i,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int CW = $clog2(ACC_WIDTH + 1);
    localparam logic [CW-1:0]        ACC_W_C = CW'(ACC_WIDTH);
    localparam logic [CW-1:0]        IN_W_C  = CW'(IN_WIDTH);
    localparam logic [CW-1:0]        EIGHT_C = CW'(8);
    localparam logic [LEN_WIDTH-1:0] IN_W_L  = LEN_WIDTH'(IN_WIDTH);
    localparam logic [ACC_WIDTH-1:0] ONES    = {ACC_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;     // pending bits, MSB-aligned; bits below the tail are always 0
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           byte_q, byte_d;
    logic                 vld_q, vld_d;
    logic                 stuff_q, stuff_d; // 0x00 owed after an emitted 0xFF
    logic                 err_q, err_d;

    logic                 out_free, load_stuff, pop, accept, len_over;
    logic [CW-1:0]        len_add, cnt_base, pad_n, ins_shift;
    logic [ACC_WIDTH-1:0] acc_base, code_ext, ins_vec, pad_vec;
    logic [7:0]           top_byte;

    assign in_ready_o   = ((state_q == IDLE) || (state_q == RUN)) &&
                          (({1'b0, cnt_q} + {1'b0, IN_W_C}) <= {1'b0, ACC_W_C});
    assign byte_o       = byte_q;
    assign byte_valid_o = vld_q;
    assign err_o        = err_q;
    assign done_o       = (state_q == DONE);
    assign busy_o       = (state_q != IDLE) || (cnt_q != '0) || vld_q;
    assign top_byte     = acc_q[ACC_WIDTH-1 -: 8];
    assign code_ext     = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, code_i};

    // Datapath: one optional pop off the head, then append (accept) or pad (flush) at the tail.
    always_comb begin
        out_free   = !vld_q || byte_ready_i;
        load_stuff = out_free && stuff_q;
        pop        = out_free && !stuff_q && (cnt_q >= EIGHT_C);
        accept     = in_valid_i && in_ready_o;
        len_over   = code_len_i > IN_W_L;

        len_add = '0;
        if (accept) begin
            len_add = len_over ? IN_W_C : CW'(code_len_i);
        end

        acc_base = pop ? (acc_q << 8) : acc_q;
        cnt_base = pop ? (cnt_q - EIGHT_C) : cnt_q;

        // Codes are masked to their length so stray high bits never leak into the stream.
        ins_shift = ACC_W_C - cnt_base - len_add;
        ins_vec   = (code_ext & ~(ONES << len_add)) << ins_shift;

        // No accepts happen in FLUSH, so once the tail is byte-aligned padding stops by itself.
        pad_n = '0;
        if ((state_q == FLUSH) && (cnt_base[2:0] != 3'd0)) begin
            pad_n = CW'(4'd8 - {1'b0, cnt_base[2:0]});
        end
        pad_vec = (ONES >> cnt_base) & ~(ONES >> (cnt_base + pad_n));

        acc_d = acc_base | ins_vec | pad_vec;
        cnt_d = cnt_base + len_add + pad_n;

        byte_d  = byte_q;
        vld_d   = vld_q;
        stuff_d = stuff_q;
        if (out_free) begin
            vld_d = load_stuff || pop;
            if (load_stuff) begin
                byte_d  = 8'h00;
                stuff_d = 1'b0;
            end else if (pop) begin
                byte_d  = top_byte;
                stuff_d = STUFF_EN && (top_byte == 8'hFF);
            end
        end

        err_d = err_q || (accept && len_over);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if ((cnt_d != '0) || vld_d || stuff_d) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            // Done once nothing is left and the last byte leaves on this edge.
            FLUSH: begin
                if ((cnt_q == '0) && !stuff_q && out_free) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
            vld_q   <= 1'b0;
            stuff_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            stuff_q <= stuff_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
module tb_jpeg_bit_packer;

    logic        clk_x8_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid;
    logic [31:0] code;
    logic [5:0]  code_len;
    logic        flush;
    logic        byte_ready;
    logic        in_ready, byte_valid, done, busy, err;
    logic [7:0]  byte_o;
    // Second instance with stuffing disabled, only fed when use0 is set.
    logic        use0 = 1'b0;
    logic        in_valid0, flush0;
    logic        in_ready0, byte_valid0, done0, busy0, err0;
    logic [7:0]  byte_o0;

    assign in_valid0 = in_valid & use0;
    assign flush0    = flush & use0;

    always #5 clk_x8_i = ~clk_x8_i;

    jpeg_bit_packer dut (
        .clk_x8_i(clk_x8_i), .rst_n_i(rst_n_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .code_i(code), .code_len_i(code_len), .flush_i(flush),
        .byte_o(byte_o), .byte_valid_o(byte_valid), .byte_ready_i(byte_ready),
        .done_o(done), .busy_o(busy), .err_o(err)
    );

    jpeg_bit_packer #(.STUFF_EN(1'b0)) dut0 (
        .clk_x8_i(clk_x8_i), .rst_n_i(rst_n_i),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .code_i(code), .code_len_i(code_len), .flush_i(flush0),
        .byte_o(byte_o0), .byte_valid_o(byte_valid0), .byte_ready_i(byte_ready),
        .done_o(done0), .busy_o(busy0), .err_o(err0)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_acc       = 0;
    int acc_cyc     = 0;
    bit stop_toggle = 1'b0;

    bit         model_bits[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp0_q[$];
    logic [7:0] got_q[$];
    logic [7:0] got0_q[$];
    int         got_cyc[$];

    always @(posedge clk_x8_i) cyc <= cyc + 1;

    always @(negedge clk_x8_i) begin
        if (rst_n_i) begin
            if (byte_valid && byte_ready) begin
                got_q.push_back(byte_o);
                got_cyc.push_back(cyc);
            end
            if (byte_valid0 && byte_ready) got0_q.push_back(byte_o0);
        end
    end

    // Reference model: a plain bit list, cut into bytes MSB-first.
    task automatic model_drain();
        while (model_bits.size() >= 8) begin
            logic [7:0] b;
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], model_bits.pop_front()};
            exp_q.push_back(b);
            exp0_q.push_back(b);
            if (b == 8'hFF) exp_q.push_back(8'h00);
        end
    endtask

    task automatic model_push(input logic [31:0] c, input int len);
        for (int i = len - 1; i >= 0; i--) model_bits.push_back(c[i]);
        model_drain();
    endtask

    task automatic model_flush();
        while ((model_bits.size() % 8) != 0) model_bits.push_back(1'b1);
        model_drain();
    endtask

    task automatic clear_all();
        model_bits.delete(); exp_q.delete(); exp0_q.delete();
        got_q.delete(); got0_q.delete(); got_cyc.delete();
    endtask

    // Entered and left at posedge+1. in_ready is register-driven, so it is stable here.
    task automatic send(input logic [31:0] c, input int len, input logic fl);
        int n;
        n = 0;
        in_valid = 1'b1; code = c; code_len = len[5:0];
        while (!(in_ready && (!use0 || in_ready0)) && n < 500) begin
            @(posedge clk_x8_i); #1; n++;
        end
        if (n >= 500) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end else begin
            flush = fl;
            @(posedge clk_x8_i); #1;
            model_push(c, (len > 32) ? 32 : len);
            n_acc++;
            acc_cyc = cyc;
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output bit timed_out);
        int k;
        k = 0;
        while (got_q.size() < n && k < 3000) begin @(negedge clk_x8_i); k++; end
        timed_out = (k >= 3000);
        repeat (4) @(negedge clk_x8_i);
        @(posedge clk_x8_i); #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; in_valid = 1'b0; code = '0; code_len = '0; flush = 1'b0; byte_ready = 1'b1;
        repeat (3) @(negedge clk_x8_i);
        vectors++; if (byte_o !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h want 00", byte_o); end
        vectors++; if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n_i = 1'b1;
        @(posedge clk_x8_i); #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_first_byte();
        int lat;
        clear_all();
        send(32'b101, 3, 1'b0);
        send(32'b11110, 5, 1'b0);
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_x8_i);
            if (byte_valid) begin lat = cyc - (acc_cyc - 1); break; end
        end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL first_latency: cycles after code cycle %0d want 2", lat); end
        vectors++; if (byte_o !== 8'hBE) begin miscompares++; $display("FAIL first_byte: got %h want be", byte_o); end
        @(negedge clk_x8_i);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL first_busy: got %b want 0", busy); end
        @(posedge clk_x8_i); #1;
        vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL first_count: got %0d bytes want 1", got_q.size()); end
    endtask

    task automatic test_word32();
        bit to;
        clear_all();
        send(32'h12345678, 32, 1'b0);
        wait_bytes(4, to);
        vectors++; if (to || got_q.size() !== 4) begin miscompares++; $display("FAIL word_count: got %0d bytes want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL word_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            vectors++; if (got_cyc[i] - got_cyc[0] !== i) begin miscompares++; $display("FAIL word_spacing[%0d]: got %0d want %0d", i, got_cyc[i] - got_cyc[0], i); end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL word_busy: got %b want 0", busy); end
    endtask

    task automatic test_stuffing();
        bit to;
        clear_all();
        use0 = 1'b1;
        send(32'hFF, 8, 1'b0);
        send(32'h01, 8, 1'b0);
        use0 = 1'b0;
        wait_bytes(3, to);
        vectors++; if (to || got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL stuff_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stuff_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (got0_q.size() !== exp0_q.size()) begin miscompares++; $display("FAIL nostuff_count: got %0d want %0d", got0_q.size(), exp0_q.size()); end
        for (int i = 0; i < got0_q.size() && i < exp0_q.size(); i++) begin
            vectors++; if (got0_q[i] !== exp0_q[i]) begin miscompares++; $display("FAIL nostuff_byte[%0d]: got %h want %h", i, got0_q[i], exp0_q[i]); end
        end
    endtask

    task automatic test_flush();
        int k;
        for (int p = 0; p < 3; p++) begin
            clear_all();
            if (p == 0)      send(32'h0, 1, 1'b1);
            else if (p == 1) send(32'h1, 1, 1'b1);
            else             send(32'h0, 0, 1'b1);
            model_flush();
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush%0d_ready: got %b want 0", p, in_ready); end
            k = 0;
            while (!done && k < 200) begin @(negedge clk_x8_i); k++; end
            vectors++; if (k >= 200) begin miscompares++; $display("FAIL flush%0d_done: done stayed 0 want 1", p); end
            if (p == 2) begin
                vectors++; if (cyc - (acc_cyc - 1) !== 2) begin miscompares++; $display("FAIL flush_empty_lat: got %0d cycles want 2", cyc - (acc_cyc - 1)); end
            end
            @(negedge clk_x8_i);
            vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL flush%0d_pulse: done %b want 0", p, done); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush%0d_busy: got %b want 0", p, busy); end
            @(posedge clk_x8_i); #1;
            vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL flush%0d_count: got %0d want %0d", p, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL flush%0d_byte[%0d]: got %h want %h", p, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int acc0;
        clear_all();
        byte_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom, 16, 1'b0);
            end
            begin
                logic [7:0] held;
                bit seen;
                seen = 1'b0; held = 8'h00;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk_x8_i);
                    if (seen) begin
                        vectors++;
                        if (byte_o !== held || byte_valid !== 1'b1) begin
                            miscompares++; $display("FAIL bp_hold: got %h/%b want %h/1", byte_o, byte_valid, held);
                        end
                    end
                    if (byte_valid) begin held = byte_o; seen = 1'b1; end
                end
                vectors++; if (n_acc - acc0 !== 3) begin miscompares++; $display("FAIL bp_accepts: got %0d want 3", n_acc - acc0); end
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b want 0", in_ready); end
                @(posedge clk_x8_i); #1;
                byte_ready = 1'b1;
            end
        join
        wait_bytes(exp_q.size(), to);
        vectors++; if (to || got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_stream();
        int k;
        clear_all();
        stop_toggle = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) send($urandom, $urandom_range(32, 0), 1'b0);
                stop_toggle = 1'b1;
            end
            begin
                while (!stop_toggle) begin
                    @(posedge clk_x8_i); #1;
                    byte_ready = ($urandom_range(3, 0) != 0);
                end
                byte_ready = 1'b1;
            end
        join
        send($urandom, $urandom_range(32, 0), 1'b1);
        model_flush();
        k = 0;
        while (!done && k < 3000) begin @(negedge clk_x8_i); k++; end
        vectors++; if (k >= 3000) begin miscompares++; $display("FAIL rand_done: done stayed 0 want 1"); end
        @(posedge clk_x8_i); #1;
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_err();
        int k;
        clear_all();
        send($urandom, 40, 1'b0);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", err); end
        send(32'h0, 0, 1'b1);
        model_flush();
        k = 0;
        while (!done && k < 200) begin @(negedge clk_x8_i); k++; end
        repeat (3) @(negedge clk_x8_i);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", err); end
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL err_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL err_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk_x8_i); #1;
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_all();
        byte_ready = 1'b0;
        send($urandom, 16, 1'b0);
        send($urandom, 16, 1'b0);
        @(negedge clk_x8_i); #2;
        rst_n_i = 1'b0;
        #1;
        vectors++; if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b want 0", byte_valid); end
        vectors++; if (byte_o !== 8'h00) begin miscompares++; $display("FAIL arst_byte: got %h want 00", byte_o); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL arst_err: got %b want 0", err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL arst_done: got %b want 0", done); end
        @(negedge clk_x8_i);
        rst_n_i = 1'b1;
        byte_ready = 1'b1;
        clear_all();
        @(posedge clk_x8_i); #1;
        send(32'hA5, 8, 1'b0);
        wait_bytes(1, to);
        vectors++; if (to || got_q.size() !== 1) begin miscompares++; $display("FAIL arst_after_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            vectors++; if (got_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL arst_after_byte: got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    initial begin
        #900000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_byte();
        test_word32();
        test_stuffing();
        test_flush();
        test_backpressure();
        test_random_stream();
        test_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jpeg_bit_packer.md
Name: jpeg_bit_packer

Overview:
Parametrised successor to the DC/AC sequence merger in the JPEG entropy path. It accepts variable-length Huffman/amplitude codes on a valid/ready interface and packs them MSB-first into a byte stream. It inserts a 0x00 after every 0xFF byte (JPEG byte stuffing) and applies output backpressure. On end of scan it flushes, padding the last partial byte with 1s. It sits between the Huffman coders and the JFIF marker/output FIFO.

Parameters:
IN_WIDTH, 32, maximum code length in bits; code_i is right-aligned.
LEN_WIDTH, 6, width of code_len_i; must satisfy 2^LEN_WIDTH > IN_WIDTH.
ACC_WIDTH, 64, accumulator depth in bits; must be >= IN_WIDTH+8.
STUFF_EN, 1, 1 enables 0xFF->0xFF00 stuffing; 0 passes bytes unmodified.

Ports:
clk_x8_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  code present
in_ready_o  out  1  code accepted when in_valid_i & in_ready_o
code_i  in  IN_WIDTH  code bits, right-aligned; bit code_len_i-1 is sent first
code_len_i  in  LEN_WIDTH  number of valid bits, 0..IN_WIDTH
flush_i  in  1  end-of-scan request, single-cycle pulse
byte_o  out  8  output byte
byte_valid_o  out  1  byte_o valid
byte_ready_i  in  1  downstream accepts byte
done_o  out  1  one-cycle pulse: flush complete
busy_o  out  1  state != IDLE or bit_cnt != 0 or byte_valid_o
err_o  out  1  sticky: code_len_i > IN_WIDTH was accepted; cleared only by reset

Behaviour:
- Reset: accumulator and bit_cnt = 0; state IDLE; byte_o=0x00; byte_valid_o, done_o, err_o, busy_o = 0.
- States: IDLE/RUN (normal packing), FLUSH (draining), DONE (one cycle, done_o=1, then IDLE).
- in_ready_o = (state is IDLE or RUN) & (bit_cnt + IN_WIDTH <= ACC_WIDTH). It is combinational from registers only.
- On accept: append code_len_i bits at the accumulator tail; bit_cnt += code_len_i. A length of 0 is legal and adds no bits.
- If code_len_i > IN_WIDTH: the length is clamped to IN_WIDTH and err_o is set.
- Byte pop: the output register loads when (!byte_valid_o | byte_ready_i) and either a stuff byte is pending or bit_cnt >= 8. A pop takes the top 8 bits and does bit_cnt -= 8.
- A pop and an accept in the same cycle give bit_cnt_next = bit_cnt + len - 8.
- Latency: byte_valid_o rises 2 clock edges after the edge that accepts the completing code, provided the output is idle.
- Stuffing (STUFF_EN=1): when 0xFF is loaded into byte_o, a stuff flag is set. The next load is 0x00 and pops no accumulator bits. Stuffed bytes are never reordered.
- Backpressure: while byte_valid_o & !byte_ready_i, byte_o and byte_valid_o hold stable. Input acceptance continues while in_ready_o allows.
- Flush: flush_i sampled high in IDLE/RUN moves the state to FLUSH and in_ready_o drops the next cycle.
  - If in_valid_i & in_ready_o occur in the same cycle as flush_i, that code is included before padding.
  - In FLUSH, if bit_cnt mod 8 != 0, it is padded with 1s up to the next byte boundary once, on entry.
  - All bytes drain, including the stuff byte produced by a padded 0xFF.
  - When bit_cnt = 0, no stuff is pending and the last byte has been accepted, the state goes to DONE. done_o pulses and the state returns to IDLE.
  - A flush with bit_cnt = 0 pulses done_o 2 cycles after flush_i.
- flush_i in FLUSH or DONE is ignored.
- An asynchronous reset mid-operation discards all pending bits, the stuff flag and the output byte immediately.

Test Plan:
- Code 0b101 (len 3) then 0b11110 (len 5), byte_ready_i=1 -> single byte 0xBE, 2 edges after the second accept; busy_o then drops.
- Code 0x12345678 (len 32) -> bytes 0x12, 0x34, 0x56, 0x78 on consecutive cycles; bit_cnt returns to 0.
- Code 0xFF (len 8) then 0x01 (len 8), STUFF_EN=1 -> 0xFF, 0x00, 0x01. With STUFF_EN=0 -> 0xFF, 0x01.
- Code 0b0 (len 1) with flush_i in the same cycle -> 0x7F, then done_o one-cycle pulse. Code 0b1 (len 1) + flush -> 0xFF, 0x00, done_o.
- byte_ready_i=0 for 10 cycles while 6 len-16 codes are offered -> in_ready_o drops once bit_cnt > 32; byte_o is held stable. After release, all 12 bytes arrive in order with none lost.
- Accept with code_len_i=40 -> err_o stays 1 until reset. Reset asserted mid-stream -> all outputs return to reset values asynchronously.
